fire_trigger: RTL
=================

Name: fire_trigger

Overview:
- Upstream stage of the fire sound generator. Turns the raw player fire button into clean one-cycle `fire` pulses.
- Each pulse feeds both the sound generator and the bullet spawner.
- Synchronises and debounces the button, enforces a cooldown between shots, and auto-repeats while the button is held.
- Limits the number of bullets alive on screen by tracking spawns against bullet-retire pulses.

Parameters:
- DEBOUNCE_CYC, 1_000_000, cycles the synchronised button must be stable before the debounced level changes (10 ms at 100 MHz).
- COOLDOWN_CYC, 20_000_000, minimum cycles from one fire pulse to the next (200 ms at 100 MHz).
- MAX_BULLETS, 4, maximum bullets alive at once (1..7).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- btn_fire  in  1  raw fire button, asynchronous to clk, active-high.
- enable  in  1  game running; when low, no new shots are started.
- bullet_free  in  1  one-cycle pulse: one bullet left the screen or hit a target.
- fire  out  1  one-cycle pulse: spawn a bullet and play the fire sound.
- active_cnt  out  3  bullets currently alive.
- ready  out  1  a shot would be accepted now.

Behaviour:
- Reset (async, active-high):
  - Sync flops, debounced level db, debounce counter, cooldown counter all 0.
  - state = IDLE, fire = 0, active_cnt = 0.
  - ready is combinational, so it equals `enable` once state = IDLE.
- Synchroniser: two flops on btn_fire give sync.
- Debounce:
  - Counter clears whenever sync == db.
  - Counter increments each cycle while sync != db.
  - When the counter reaches DEBOUNCE_CYC-1 with sync still != db: db <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes db.
- State machine, states IDLE, ARMED, COOL:
  - IDLE:
    - db=1 & enable=1 & active_cnt<MAX_BULLETS -> fire=1 next cycle, go COOL.
    - db=1 & enable=1 & active_cnt==MAX_BULLETS -> go ARMED.
  - ARMED:
    - db=0 or enable=0 -> IDLE, no shot.
    - active_cnt<MAX_BULLETS -> fire=1, go COOL.
  - COOL:
    - Cooldown counter runs from the fire cycle (count 0).
    - At count COOLDOWN_CYC-1 -> IDLE.
    - Button and enable are ignored while in COOL.
- Auto-repeat: a held button (db stays 1) fires every COOLDOWN_CYC cycles while slots are free.
- fire is registered, high exactly one cycle per shot, never on two consecutive cycles.
- Latency: fire rises DEBOUNCE_CYC+3 cycles after the first clk edge sampling btn_fire high, when stable and ready.
- active_cnt:
  - fire alone: +1.
  - bullet_free alone: -1.
  - Both in the same cycle: unchanged.
  - bullet_free at 0: ignored, no underflow.
  - Never exceeds MAX_BULLETS.
- Slot check: the ARMED/IDLE decision uses the registered active_cnt. A bullet_free arriving in the same cycle is seen one cycle later.
- ready = (state==IDLE) & enable & (active_cnt<MAX_BULLETS).
- enable falling while in COOL: the cooldown completes normally, then no further shots.
- Reset mid-cooldown or mid-debounce: everything clears immediately. The next shot needs a fresh full debounce.
- Counter widths: sized from the parameters with $clog2. No wrap is possible because every counter clears at its terminal count.

Decomposition:
- Shared package (sound_pkg) holds:
  - the clock-frequency constant, 100_000_000;
  - the default DEBOUNCE_CYC and COOLDOWN_CYC;
  - the state encoding constants FT_IDLE=2'd0, FT_ARMED=2'd1, FT_COOL=2'd2.
- One sub-module: debounce_sync.
  - Contains the 2-flop synchroniser plus the debounce counter.
  - Parameter: DEBOUNCE_CYC.
  - Ports: clk, reset, din, dout.
  - Reusable for the other game buttons.
- FSM, cooldown counter and bullet counter stay in fire_trigger.

Test Plan:
- Bench parameters: DEBOUNCE_CYC=4, COOLDOWN_CYC=10, MAX_BULLETS=2.
- Single press: btn high 20 cycles, then low -> exactly one fire pulse, 7 cycles after the first sampled high edge; active_cnt 0->1.
- Glitch rejection: btn high 3 cycles, then low -> no fire pulse; db stays 0.
- Hold auto-repeat: btn held 40 cycles, no bullet_free -> fire at t0 and t0+10 only; active_cnt=2; then ARMED, ready=0, no third pulse.
- Slot release: continue holding; pulse bullet_free at t0+25 -> fire one cycle after active_cnt drops to 1; active_cnt returns to 2.
- Simultaneous: fire and bullet_free in the same cycle -> active_cnt unchanged. bullet_free with active_cnt=0 -> stays 0.
- Reset mid-cooldown: assert reset 3 cycles after a fire -> fire=0, active_cnt=0, state IDLE immediately. After release, a held btn fires only after a fresh DEBOUNCE_CYC+3 cycles.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared constants and types for the fire sound generator blocks.
// Holds the clock rate, default button timings and the fire-trigger state encoding.
package sound_pkg;

    localparam int unsigned CLK_FREQ_HZ      = 100_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int unsigned DEF_COOLDOWN_CYC = 20_000_000;

    typedef enum logic [1:0] {
        FT_IDLE  = 2'd0,
        FT_ARMED = 2'd1,
        FT_COOL  = 2'd2
    } ft_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a debouncer for one mechanical button.
// dout follows din only after the synchronised input has been stable for DEBOUNCE_CYC cycles.
module debounce_sync
    import sound_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int unsigned   CW   = cnt_w(DEBOUNCE_CYC);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYC - 1);

    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        db_d   = db_q;
        cnt_d  = '0;
        // Any cycle where sync agrees with db restarts the stability window.
        if (sync_q != db_q) begin
            if (cnt_q == TERM) begin
                db_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/fire_trigger.sv
// Turns the raw fire button into one-cycle fire pulses with cooldown, auto-repeat
// and a cap on the number of bullets alive on screen.
module fire_trigger
    import sound_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned COOLDOWN_CYC = DEF_COOLDOWN_CYC,
    parameter int unsigned MAX_BULLETS  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_fire,
    input  logic       enable,
    input  logic       bullet_free,
    output logic       fire,
    output logic [2:0] active_cnt,
    output logic       ready
);

    localparam int unsigned    CCW       = cnt_w(COOLDOWN_CYC);
    // IDLE is re-entered while the count would read COOLDOWN_CYC-1, so the next
    // shot lands exactly COOLDOWN_CYC cycles after the previous one (needs COOLDOWN_CYC >= 2).
    localparam logic [CCW-1:0] COOL_EXIT = CCW'((COOLDOWN_CYC >= 2) ? COOLDOWN_CYC - 2 : 0);
    localparam logic [2:0]     MAX3      = 3'(MAX_BULLETS);

    logic           db;
    logic           slot_free;
    ft_state_e      state_q, state_d;
    logic           fire_q, fire_d;
    logic [CCW-1:0] cool_q, cool_d;
    logic [2:0]     active_q, active_d;

    debounce_sync #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .din  (btn_fire),
        .dout (db)
    );

    assign slot_free = (active_q < MAX3);

    always_comb begin
        state_d = state_q;
        fire_d  = 1'b0;
        cool_d  = cool_q;
        unique case (state_q)
            FT_IDLE: begin
                if (db && enable) begin
                    if (slot_free) begin
                        fire_d  = 1'b1;
                        cool_d  = '0;
                        state_d = FT_COOL;
                    end else begin
                        state_d = FT_ARMED;
                    end
                end
            end
            FT_ARMED: begin
                if (!db || !enable) begin
                    state_d = FT_IDLE;
                end else if (slot_free) begin
                    fire_d  = 1'b1;
                    cool_d  = '0;
                    state_d = FT_COOL;
                end
            end
            FT_COOL: begin
                if (cool_q == COOL_EXIT) begin
                    cool_d  = '0;
                    state_d = FT_IDLE;
                end else begin
                    cool_d = cool_q + 1'b1;
                end
            end
            default: begin
                cool_d  = '0;
                state_d = FT_IDLE;
            end
        endcase
    end

    // Bullet bookkeeping follows the fire output pulse; a coincident retire cancels it.
    always_comb begin
        active_d = active_q;
        unique case ({fire_q, bullet_free})
            2'b10:   if (active_q < MAX3) active_d = active_q + 3'd1;
            2'b01:   if (active_q != 3'd0) active_d = active_q - 3'd1;
            default: active_d = active_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FT_IDLE;
            fire_q   <= 1'b0;
            cool_q   <= '0;
            active_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            fire_q   <= fire_d;
            cool_q   <= cool_d;
            active_q <= active_d;
        end
    end

    assign fire       = fire_q;
    assign active_cnt = active_q;
    assign ready      = (state_q == FT_IDLE) && enable && slot_free;

endmodule
